// File: rtl/rom_burst_loader_pkg.sv
// Shared state encoding and sizing helper for the ROM burst loader.
package rom_burst_loader_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_BURST,
        S_DRAIN
    } state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/rom_burst_loader_sync_fifo.sv
// Single-clock show-ahead FIFO with a registered occupancy count and a
// sticky underflow flag.
module sync_fifo
    import rom_burst_loader_pkg::*;
#(
    parameter int DW    = 3,
    parameter int DEPTH = 1024
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    push_i,
    input  logic [DW-1:0]           din_i,
    input  logic                    pop_i,
    output logic [DW-1:0]           dout_o,
    output logic                    empty_o,
    output logic [clog2(DEPTH):0]   used_o,
    output logic                    err_o
);
    localparam int PW = clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [PW:0]   used_q, used_d;
    logic          err_q, err_d;
    logic          do_push, do_pop;

    assign empty_o = (used_q == '0);
    assign do_push = push_i && !used_q[PW];
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_d   = wr_q + PW'(do_push);
        rd_d   = rd_q + PW'(do_pop);
        used_d = used_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
        err_d  = err_q | (pop_i & empty_o);
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q   <= '0;
            rd_q   <= '0;
            used_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            used_q <= used_d;
            err_q  <= err_d;
        end
    end

    // Head is forced to zero while empty so stale storage never leaks out.
    assign dout_o = empty_o ? '0 : mem_q[rd_q];
    assign used_o = used_q;
    assign err_o  = err_q;

endmodule

// File: rtl/rom_burst_loader.sv
// Streams a programmable ROM window into a show-ahead FIFO in credit-checked
// bursts, with optional looping and a done/error status.
module rom_burst_loader
    import rom_burst_loader_pkg::*;
#(
    parameter int DW      = 3,
    parameter int AW      = 16,
    parameter int DEPTH   = 1024,
    parameter int BURST   = 256,
    parameter int THRESH  = 512,
    parameter int ROM_LAT = 1
) (
    input  logic                  clk_100M_i,
    input  logic                  rst_100i,
    input  logic                  start_i,
    input  logic                  loop_i,
    input  logic                  stop_i,
    input  logic [AW-1:0]         base_add_i,
    input  logic [AW:0]           len_i,
    output logic [AW-1:0]         rdrom_add_o,
    input  logic [DW-1:0]         rom_dat_i,
    input  logic                  rd_fifo_i,
    output logic [DW-1:0]         fifo_dat_o,
    output logic                  fifo_empty_o,
    output logic [clog2(DEPTH):0] fifo_used_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  rd_err_o
);
    localparam int UW = clog2(DEPTH) + 1;
    localparam int BW = clog2(BURST) + 1;

    state_e              state_q, state_d;
    logic [AW-1:0]       base_q, base_d;
    logic [AW:0]         len_q, len_d, off_q, off_d;
    logic                loop_q, loop_d, stop_q, stop_d, done_q, done_d;
    logic [BW-1:0]       bcnt_q, bcnt_d;
    logic [UW-1:0]       infl_q, infl_d;
    logic [ROM_LAT-1:0]  vld_pipe_q;
    logic                issue, push, last_word, burst_end, credit_ok;
    logic [UW:0]         need;

    assign issue     = (state_q == S_BURST);
    assign push      = vld_pipe_q[ROM_LAT-1];
    assign last_word = ((off_q + (AW+1)'(1)) == len_q);
    assign burst_end = last_word || (bcnt_q == BW'(BURST - 1));
    // Words already queued plus words still inside the ROM both consume credit.
    assign need      = {1'b0, fifo_used_o} + {1'b0, infl_q};
    assign credit_ok = (need <= (UW+1)'(THRESH));

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        len_d   = len_q;
        loop_d  = loop_q;
        stop_d  = stop_q | (stop_i & (state_q != S_IDLE));
        off_d   = off_q;
        bcnt_d  = bcnt_q;
        done_d  = 1'b0;
        infl_d  = infl_q + UW'(issue) - UW'(push);
        case (state_q)
            S_IDLE: if (start_i) begin
                base_d  = base_add_i;
                len_d   = (len_i == '0) ? (AW+1)'(1) : len_i;
                loop_d  = loop_i;
                stop_d  = 1'b0;
                off_d   = '0;
                state_d = S_CHECK;
            end
            S_CHECK: if (credit_ok) begin
                bcnt_d  = '0;
                state_d = S_BURST;
            end
            S_BURST: begin
                off_d  = off_q + (AW+1)'(1);
                bcnt_d = bcnt_q + BW'(1);
                if (burst_end) begin
                    if (!last_word) begin
                        state_d = S_CHECK;
                    end else if (loop_q && !stop_d) begin
                        off_d   = '0;
                        state_d = S_CHECK;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: if (infl_q == '0) begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_100M_i) begin
        if (rst_100i) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            len_q      <= '0;
            loop_q     <= 1'b0;
            stop_q     <= 1'b0;
            off_q      <= '0;
            bcnt_q     <= '0;
            done_q     <= 1'b0;
            infl_q     <= '0;
            vld_pipe_q <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            len_q      <= len_d;
            loop_q     <= loop_d;
            stop_q     <= stop_d;
            off_q      <= off_d;
            bcnt_q     <= bcnt_d;
            done_q     <= done_d;
            infl_q     <= infl_d;
            vld_pipe_q <= (vld_pipe_q << 1) | ROM_LAT'(issue);
        end
    end

    assign rdrom_add_o = base_q + off_q[AW-1:0];
    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = done_q;

    sync_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_100M_i),
        .rst_i   (rst_100i),
        .push_i  (push),
        .din_i   (rom_dat_i),
        .pop_i   (rd_fifo_i),
        .dout_o  (fifo_dat_o),
        .empty_o (fifo_empty_o),
        .used_o  (fifo_used_o),
        .err_o   (rd_err_o)
    );

endmodule

// File: tb/tb_rom_burst_loader.sv
// Directed bench: a ROM model returning its own address feeds the loader and
// a scoreboard queue of expected words is checked as the consumer pops.
module tb_rom_burst_loader;
    localparam int DW = 16, AW = 16, DEPTH = 1024, BURST = 256, THRESH = 512, ROM_LAT = 1;

    logic          clk = 1'b0, rst = 1'b1;
    logic          start_i = 0, loop_i = 0, stop_i = 0, rd_fifo_i = 0;
    logic [AW-1:0] base_add_i = '0;
    logic [AW:0]   len_i = '0;
    logic [AW-1:0] rdrom_add_o;
    logic [DW-1:0] rom_dat_i = '0, fifo_dat_o;
    logic          fifo_empty_o, busy_o, done_o, rd_err_o;
    logic [10:0]   fifo_used_o;

    int n_chk = 0, n_fail = 0, done_cnt = 0, pop_cnt = 0, max_used = 0;
    logic consume = 0, force_pop = 0, prev_busy = 0;
    logic [DW-1:0] exp_q[$];

    always #5 clk = ~clk;

    rom_burst_loader #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .BURST(BURST),
                       .THRESH(THRESH), .ROM_LAT(ROM_LAT)) dut (
        .clk_100M_i(clk), .rst_100i(rst), .start_i(start_i), .loop_i(loop_i),
        .stop_i(stop_i), .base_add_i(base_add_i), .len_i(len_i),
        .rdrom_add_o(rdrom_add_o), .rom_dat_i(rom_dat_i), .rd_fifo_i(rd_fifo_i),
        .fifo_dat_o(fifo_dat_o), .fifo_empty_o(fifo_empty_o), .fifo_used_o(fifo_used_o),
        .busy_o(busy_o), .done_o(done_o), .rd_err_o(rd_err_o));

    // One-cycle-latency ROM whose content is its own address.
    always @(posedge clk) rom_dat_i <= rdrom_add_o;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Consumer, scoreboard and status monitor.
    always @(negedge clk) begin
        rd_fifo_i = force_pop | (consume & ~fifo_empty_o);
        if (!rst) begin
            if (rd_fifo_i && !fifo_empty_o) begin
                pop_cnt++;
                if (exp_q.size() == 0) chk("extra_word", 32'(fifo_dat_o), 32'hFFFF_FFFF);
                else chk("data", 32'(fifo_dat_o), 32'(exp_q.pop_front()));
            end
            if (done_o) begin
                done_cnt++;
                chk("busy_low_with_done", 32'(busy_o), 0);
                chk("busy_before_done", 32'(prev_busy), 1);
            end
            chk("credit_bound", 32'(fifo_used_o <= 11'(THRESH + BURST)), 1);
            if (int'(fifo_used_o) > max_used) max_used = int'(fifo_used_o);
        end
        prev_busy = busy_o;
    end

    task automatic push_exp(input logic [AW-1:0] base, input int len, input int passes);
        for (int p = 0; p < passes; p++)
            for (int i = 0; i < len; i++) exp_q.push_back(DW'(base + AW'(i)));
    endtask

    task automatic do_start(input logic [AW-1:0] base, input int len, input logic lp);
        base_add_i = base;
        len_i      = (AW+1)'(len);
        loop_i     = lp;
        start_i    = 1'b1;
        @(negedge clk);
        start_i    = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int c;
        c = 0;
        while (done_cnt == 0 && c < 4000) begin @(negedge clk); c++; end
        chk({tag, "_done_seen"}, 32'(done_cnt != 0), 1);
    endtask

    task automatic drain(input string tag, input int exp_pops);
        int c;
        c = 0;
        consume = 1'b1;
        while ((exp_q.size() != 0 || !fifo_empty_o) && c < 4000) begin @(negedge clk); c++; end
        repeat (4) @(negedge clk);
        chk({tag, "_queue_left"}, exp_q.size(), 0);
        chk({tag, "_pops"}, pop_cnt, exp_pops);
        chk({tag, "_done_once"}, done_cnt, 1);
        chk({tag, "_idle"}, 32'(busy_o), 0);
    endtask

    task automatic new_test();
        done_cnt = 0;
        pop_cnt  = 0;
        max_used = 0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_addr", 32'(rdrom_add_o), 0);
        chk("rst_dat", 32'(fifo_dat_o), 0);
        chk("rst_empty", 32'(fifo_empty_o), 1);
        chk("rst_used", 32'(fifo_used_o), 0);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_done", 32'(done_o), 0);
        chk("rst_err", 32'(rd_err_o), 0);
        rst = 1'b0;
        @(negedge clk);

        // Pop while empty: sticky error, occupancy untouched.
        force_pop = 1'b1;
        @(negedge clk);
        force_pop = 1'b0;
        @(negedge clk);
        chk("err_set", 32'(rd_err_o), 1);
        chk("err_used", 32'(fifo_used_o), 0);
        repeat (5) @(negedge clk);
        chk("err_sticky", 32'(rd_err_o), 1);

        // One-shot 1024 words, continuous consumer, first-word latency.
        new_test();
        consume = 1'b1;
        push_exp(16'h0000, 1024, 1);
        do_start(16'h0000, 1024, 1'b0);
        chk("busy_after_start", 32'(busy_o), 1);
        @(negedge clk);
        @(negedge clk);
        chk("lat_empty_before", 32'(fifo_empty_o), 1);
        @(negedge clk);
        chk("lat_first_word", 32'(fifo_empty_o), 0);
        repeat (100) @(negedge clk);
        do_start(16'h5000, 8, 1'b0);
        wait_done("oneshot");
        drain("oneshot", 1024);

        // Stalled consumer: fill stops at THRESH + BURST.
        new_test();
        consume = 1'b0;
        push_exp(16'h0000, 1024, 1);
        do_start(16'h0000, 1024, 1'b0);
        repeat (1000) @(negedge clk);
        chk("stall_used", 32'(fifo_used_o), 32'(THRESH + BURST));
        chk("stall_peak", max_used, THRESH + BURST);
        chk("stall_busy", 32'(busy_o), 1);
        consume = 1'b1;
        wait_done("stall");
        drain("stall", 1024);

        // Window wrapping past the top of the address space.
        new_test();
        push_exp(16'hFF80, 256, 1);
        do_start(16'hFF80, 256, 1'b0);
        wait_done("wrap");
        drain("wrap", 256);

        // Partial last burst (256 + 44); stop is ignored in one-shot mode.
        new_test();
        consume = 1'b0;
        push_exp(16'h1234, 300, 1);
        do_start(16'h1234, 300, 1'b0);
        repeat (20) @(negedge clk);
        stop_i = 1'b1;
        @(negedge clk);
        stop_i = 1'b0;
        wait_done("len300");
        chk("len300_used", 32'(fifo_used_o), 300);
        drain("len300", 300);

        // Loop mode: stop during the third pass, that pass completes.
        new_test();
        push_exp(16'h0100, 16, 3);
        do_start(16'h0100, 16, 1'b1);
        repeat (42) @(negedge clk);
        stop_i = 1'b1;
        @(negedge clk);
        stop_i = 1'b0;
        wait_done("loop");
        drain("loop", 48);

        // Reset mid-burst abandons the transfer and clears the error flag.
        new_test();
        consume = 1'b0;
        do_start(16'h0000, 1024, 1'b0);
        repeat (20) @(negedge clk);
        chk("pre_rst_err", 32'(rd_err_o), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_addr", 32'(rdrom_add_o), 0);
        chk("mid_rst_dat", 32'(fifo_dat_o), 0);
        chk("mid_rst_empty", 32'(fifo_empty_o), 1);
        chk("mid_rst_used", 32'(fifo_used_o), 0);
        chk("mid_rst_busy", 32'(busy_o), 0);
        chk("mid_rst_err", 32'(rd_err_o), 0);
        rst = 1'b0;
        exp_q.delete();
        repeat (3) @(negedge clk);
        chk("post_rst_used", 32'(fifo_used_o), 0);

        // Recovery after reset, len 0 treated as one word.
        new_test();
        push_exp(16'h0020, 1, 1);
        do_start(16'h0020, 0, 1'b0);
        wait_done("len0");
        drain("len0", 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rom_burst_loader.md
Name: rom_burst_loader

Overview:
Parametrised ROM-to-FIFO streamer. It reads a programmable window of a synchronous ROM in fixed-length bursts into an internal single-clock show-ahead FIFO, which the SDRAM write path drains. Compared with the previous loader it adds configurable widths and depth, a base address and length, loop mode, ROM latency compensation, credit-based overflow protection, and a done/error status.

Parameters:
DW, 3, ROM/FIFO data width
AW, 16, ROM address width
DEPTH, 1024, FIFO depth in words (power of 2)
BURST, 256, words per burst (power of 2, <= DEPTH)
THRESH, 512, refill when (fifo_used + in-flight) <= THRESH; legal range 0..DEPTH-BURST
ROM_LAT, 1, ROM read latency in cycles (>= 1)

Ports:
clk_100M_i  in  1  single system clock
rst_100i  in  1  synchronous reset, active-high
start_i  in  1  one-cycle pulse; begins a transfer when idle
loop_i  in  1  sampled at start; 1 = restart at base after each pass
stop_i  in  1  pulse; ends a loop-mode transfer at the next burst boundary
base_add_i  in  AW  first ROM address, sampled at start
len_i  in  AW+1  words per pass, sampled at start; 0 is treated as 1
rdrom_add_o  out  AW  ROM read address
rom_dat_i  in  DW  ROM data, valid ROM_LAT cycles after the address
rd_fifo_i  in  1  pop request from the downstream consumer
fifo_dat_o  out  DW  FIFO head word, valid when fifo_empty_o = 0
fifo_empty_o  out  1  FIFO empty
fifo_used_o  out  log2(DEPTH)+1  FIFO occupancy
busy_o  out  1  transfer in progress
done_o  out  1  one-cycle pulse at end of transfer
rd_err_o  out  1  sticky flag: pop attempted while empty

Behaviour:
- Reset: all outputs are 0. FIFO is flushed, state is IDLE, rd_err_o is cleared. Reset asserted mid-burst abandons the burst; in-flight ROM words are discarded.
- States:
  - IDLE: start_i latches base, len and loop, clears the offset counter, then goes to CHECK. busy_o = 1 in every state except IDLE.
  - CHECK: if (used + inflight) <= THRESH, go to BURST; otherwise stay.
  - BURST: issues one address per cycle, rdrom_add_o = (base + offset) mod 2^AW. A burst is min(BURST, len - offset) words.
  - End of burst, words remaining in the pass: go to CHECK.
  - End of burst, pass complete, one-shot mode: go to DRAIN.
  - End of burst, pass complete, loop mode: clear the offset and go to CHECK, or go to DRAIN if stop was latched.
  - DRAIN: wait until inflight = 0, pulse done_o, return to IDLE.
- Address issue: each issued address enters a ROM_LAT-deep valid shift register. Its output pushes rom_dat_i into the FIFO. inflight counts issued words not yet pushed.
- Credit rule: the CHECK condition together with THRESH <= DEPTH-BURST guarantees a push never finds the FIFO full. The bench checks this by assertion.
- FIFO is show-ahead: fifo_dat_o is valid when fifo_empty_o = 0. A pop with empty = 1 is ignored and sets rd_err_o. Push and pop in the same cycle leave used unchanged; when empty, the pushed word appears at the head on the next cycle.
- fifo_used_o is registered and updates the cycle after the push/pop.
- Address arithmetic is mod 2^AW. A window crossing the top address wraps to 0.
- stop_i is latched and honoured only at a pass boundary in loop mode. It is ignored in one-shot mode and in IDLE.
- start_i while busy is ignored. stop_i in the same cycle as start_i is ignored.
- Latency: first address issued 2 cycles after start_i (IDLE -> CHECK -> BURST). First word at the FIFO head ROM_LAT + 1 cycles after its address.

Decomposition:
- Shared package holds the state encoding (S_IDLE, S_CHECK, S_BURST, S_DRAIN) and the clog2 helper.
- Sub-module sync_fifo (parameters DW, DEPTH; show-ahead, registered used count). The top level holds the FSM, counters and latency pipe.

Test Plan:
- base = 0x0000, len = 1024, loop = 0, ROM returns its address[2:0], consumer pops continuously -> 1024 words in order 0,1,...,7,0,...; done_o pulses once; busy_o falls with done_o.
- Same stimulus with the consumer stalled -> FIFO fills to exactly 768 (512 + 256) and stops with no overflow; releasing the consumer completes all 1024 words.
- base = 0xFF80, len = 256 -> addresses 0xFF80..0xFFFF then 0x0000..0x007F; last burst issues 256 words; done_o pulses.
- len = 300, BURST = 256 -> two bursts of 256 and 44 words; total 300 pushes.
- loop = 1, len = 16, stop_i pulse mid-pass -> current pass completes; pass count = floor + 1; done_o pulses once after drain.
- Pop while empty after reset -> rd_err_o = 1 and stays 1; fifo_used_o = 0. Reset mid-burst -> all outputs 0 and FIFO empty on the next cycle.
